// File: rtl/ship_board.sv
// ship_board: one player's board for a single-cell-ship battleship game.
//
// Placement: a rising edge of place_req requests a ship at cell_pos. Out-of-range
// cells are rejected on the next cycle. Legal targets are scanned against their
// 3x3 neighbourhood, one cell per cycle, because ships may not touch, diagonals
// included. The result appears as place_ack or place_err ten cycles after the edge.
// When MAX_SHIPS ships are placed, the board arms and starts accepting shots.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clear             synchronous board wipe; same effect as rst
//   place_req         placement request level; only its rising edge matters
//   cell_pos          placement cell, [7:4] row, [3:0] column
//   place_ack/err     one-cycle placement result pulses
//   ship_count        ships placed so far; board_full when it equals MAX_SHIPS
//   query_valid/pos   shot request and cell; query_ready says it can be taken
//   resp_valid        one-cycle pulse with resp_hit / resp_repeat
//   all_sunk          every ship has been hit; holds until rst or clear
//   occ_map, shot_map ship and fired-at bitmaps, bit row*BOARD_N+col
module ship_board #(
    parameter int BOARD_N   = 10,
    parameter int MAX_SHIPS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       place_req,
    input  logic [7:0]                 cell_pos,
    output logic                       place_ack,
    output logic                       place_err,
    output logic [3:0]                 ship_count,
    output logic                       board_full,
    input  logic                       query_valid,
    input  logic [7:0]                 query_pos,
    output logic                       query_ready,
    output logic                       resp_valid,
    output logic                       resp_hit,
    output logic                       resp_repeat,
    output logic                       all_sunk,
    output logic [BOARD_N*BOARD_N-1:0] occ_map,
    output logic [BOARD_N*BOARD_N-1:0] shot_map
);

    localparam int          Cells  = BOARD_N * BOARD_N;
    localparam int          IdxW   = $clog2(Cells);
    localparam logic [3:0]  MaxCnt = 4'(MAX_SHIPS);

    typedef enum logic [1:0] {StReady, StCheck, StCommit, StArmed} state_e;

    state_e           state_q, state_d;
    logic             place_req_q;
    logic [7:0]       tgt_q, tgt_d;
    logic [3:0]       scan_q, scan_d;
    logic             conflict_q, conflict_d;
    logic [Cells-1:0] occ_q, occ_d;
    logic [Cells-1:0] shot_q, shot_d;
    logic [3:0]       count_q, count_d;
    logic [3:0]       hits_q, hits_d;
    logic             ack_q, ack_d, err_q, err_d;
    logic             rv_q, rv_d, rh_q, rh_d, rr_q, rr_d;
    logic             sunk_q, sunk_d;

    logic             place_edge, cell_ok, q_ok, nb_on, nb_occ;
    int               nb_row, nb_col;
    logic [IdxW-1:0]  nb_idx, tgt_idx, q_idx;

    assign place_edge = place_req & ~place_req_q;
    assign cell_ok    = (int'(cell_pos[7:4]) < BOARD_N) && (int'(cell_pos[3:0]) < BOARD_N);
    assign q_ok       = (int'(query_pos[7:4]) < BOARD_N) && (int'(query_pos[3:0]) < BOARD_N);

    // Scan step s covers offset (s/3 - 1, s%3 - 1); off-board neighbours read as free.
    assign nb_row  = int'(tgt_q[7:4]) + int'(scan_q) / 3 - 1;
    assign nb_col  = int'(tgt_q[3:0]) + int'(scan_q) % 3 - 1;
    assign nb_on   = (nb_row >= 0) && (nb_row < BOARD_N) && (nb_col >= 0) && (nb_col < BOARD_N);
    assign nb_idx  = nb_on ? IdxW'(nb_row * BOARD_N + nb_col) : '0;
    assign nb_occ  = nb_on && occ_q[nb_idx];
    assign tgt_idx = IdxW'(int'(tgt_q[7:4]) * BOARD_N + int'(tgt_q[3:0]));
    assign q_idx   = q_ok ? IdxW'(int'(query_pos[7:4]) * BOARD_N + int'(query_pos[3:0])) : '0;

    assign query_ready = (state_q == StArmed) && !sunk_q;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        scan_d     = scan_q;
        conflict_d = conflict_q;
        occ_d      = occ_q;
        shot_d     = shot_q;
        count_d    = count_q;
        hits_d     = hits_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rv_d       = 1'b0;
        rh_d       = 1'b0;
        rr_d       = 1'b0;
        // Registered so it rises the cycle after the hit counter completes.
        sunk_d     = sunk_q | (hits_q == MaxCnt);

        unique case (state_q)
            StReady: begin
                if (place_edge) begin
                    if (!cell_ok) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d      = cell_pos;
                        scan_d     = 4'd0;
                        conflict_d = 1'b0;
                        state_d    = StCheck;
                    end
                end
            end
            StCheck: begin
                conflict_d = conflict_q | nb_occ;
                scan_d     = scan_q + 4'd1;
                if (scan_q == 4'd8) begin
                    // Result pulses are registered here so they show during COMMIT.
                    state_d = StCommit;
                    ack_d   = ~conflict_d;
                    err_d   = conflict_d;
                end
            end
            StCommit: begin
                if (!conflict_q) begin
                    occ_d[tgt_idx] = 1'b1;
                    if (count_q != MaxCnt) count_d = count_q + 4'd1;
                end
                state_d = (count_d == MaxCnt) ? StArmed : StReady;
            end
            StArmed: begin
                if (query_valid && query_ready) begin
                    rv_d = 1'b1;
                    if (q_ok) begin
                        if (shot_q[q_idx]) begin
                            rr_d = 1'b1;
                        end else begin
                            shot_d[q_idx] = 1'b1;
                            rh_d          = occ_q[q_idx];
                            if (occ_q[q_idx] && hits_q != MaxCnt) hits_d = hits_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= StReady;
            place_req_q <= 1'b0;
            tgt_q       <= '0;
            scan_q      <= '0;
            conflict_q  <= 1'b0;
            occ_q       <= '0;
            shot_q      <= '0;
            count_q     <= '0;
            hits_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rv_q        <= 1'b0;
            rh_q        <= 1'b0;
            rr_q        <= 1'b0;
            sunk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            place_req_q <= place_req;
            tgt_q       <= tgt_d;
            scan_q      <= scan_d;
            conflict_q  <= conflict_d;
            occ_q       <= occ_d;
            shot_q      <= shot_d;
            count_q     <= count_d;
            hits_q      <= hits_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rv_q        <= rv_d;
            rh_q        <= rh_d;
            rr_q        <= rr_d;
            sunk_q      <= sunk_d;
        end
    end

    assign place_ack   = ack_q;
    assign place_err   = err_q;
    assign ship_count  = count_q;
    assign board_full  = (count_q == MaxCnt);
    assign resp_valid  = rv_q;
    assign resp_hit    = rh_q;
    assign resp_repeat = rr_q;
    assign all_sunk    = sunk_q;
    assign occ_map     = occ_q;
    assign shot_map    = shot_q;

endmodule

// File: tb/tb_ship_board.sv
// Self-checking bench for ship_board: randomized placement and shooting
// compared against a board model kept as plain 2-D arrays.
module tb_ship_board;

    localparam int N  = 10;
    localparam int MS = 10;
    localparam int NC = N * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0, clear = 1'b0, place_req = 1'b0, query_valid = 1'b0;
    logic [7:0]    cell_pos = 8'h00, query_pos = 8'h00;
    logic          place_ack, place_err, board_full, query_ready;
    logic          resp_valid, resp_hit, resp_repeat, all_sunk;
    logic [3:0]    ship_count;
    logic [NC-1:0] occ_map, shot_map;

    always #5 clk = ~clk;

    ship_board #(.BOARD_N(N), .MAX_SHIPS(MS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .place_req(place_req), .cell_pos(cell_pos),
        .place_ack(place_ack), .place_err(place_err), .ship_count(ship_count),
        .board_full(board_full), .query_valid(query_valid), .query_pos(query_pos),
        .query_ready(query_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_repeat(resp_repeat), .all_sunk(all_sunk), .occ_map(occ_map),
        .shot_map(shot_map)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Board model
    bit         m_occ[N][N];
    bit         m_shot[N][N];
    int         m_count;
    int         m_hits;
    logic [7:0] ship_q[$];

    function automatic logic [NC-1:0] model_map(input bit shots);
        logic [NC-1:0] v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[r*N+c] = shots ? m_shot[r][c] : m_occ[r][c];
        return v;
    endfunction

    function automatic bit model_legal(input int r, input int c);
        if (r >= N || c >= N) return 1'b0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r + dr >= 0 && r + dr < N && c + dc >= 0 && c + dc < N)
                    if (m_occ[r+dr][c+dc]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m_occ[r][c]  = 1'b0;
                m_shot[r][c] = 1'b0;
            end
        m_count = 0;
        m_hits  = 0;
        ship_q.delete();
    endtask

    task automatic pulse_reset(input bit use_clear);
        @(negedge clk);
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        place_req   = 1'b0;
        query_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        rst   = 1'b0;
        model_clear();
    endtask

    // Issue one placement edge and place the model's prediction next to what the DUT did.
    task automatic test_place_one(input logic [7:0] pos, input string name);
        int r, c, e_ack, e_err, e_pul, ack_lat, err_lat, pul;
        r = int'(pos[7:4]);
        c = int'(pos[3:0]);
        e_ack = -1; e_err = -1; e_pul = 1;
        if (m_count == MS) e_pul = 0;
        else if (r >= N || c >= N) e_err = 1;
        else if (!model_legal(r, c)) e_err = 10;
        else begin
            e_ack = 10;
            m_occ[r][c] = 1'b1;
            m_count++;
            ship_q.push_back(pos);
        end
        @(negedge clk);
        cell_pos  = pos;
        place_req = 1'b1;
        @(posedge clk); #1;
        ack_lat = -1; err_lat = -1; pul = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (place_ack) begin if (ack_lat < 0) ack_lat = cyc; pul++; end
            if (place_err) begin if (err_lat < 0) err_lat = cyc; pul++; end
            if (cyc == 1) place_req = 1'b0;
            @(posedge clk); #1;
        end
        n_tests++;
        if (ack_lat !== e_ack || err_lat !== e_err || pul !== e_pul) begin
            n_fail++;
            $display("FAIL %s pos=%h: ack_lat=%0d err_lat=%0d pulses=%0d, need %0d %0d %0d",
                     name, pos, ack_lat, err_lat, pul, e_ack, e_err, e_pul);
        end
        n_tests++;
        if (ship_count !== 4'(m_count) || occ_map !== model_map(1'b0)
            || board_full !== (m_count == MS)) begin
            n_fail++;
            $display("FAIL %s_state pos=%h: count=%0d full=%b occ=%h, need %0d %b %h", name,
                     pos, ship_count, board_full, occ_map, m_count, m_count == MS,
                     model_map(1'b0));
        end
    endtask

    // Fire one shot and compare the response against the model.
    task automatic test_shot_one(input logic [7:0] pos, input string name);
        int r, c;
        bit e_rdy, e_hit, e_rep;
        logic rdy;
        r = int'(pos[7:4]);
        c = int'(pos[3:0]);
        e_rdy = (m_count == MS) && (m_hits < MS);
        e_hit = 1'b0; e_rep = 1'b0;
        if (e_rdy && r < N && c < N) begin
            if (m_shot[r][c]) e_rep = 1'b1;
            else begin
                m_shot[r][c] = 1'b1;
                e_hit = m_occ[r][c];
                if (e_hit) m_hits++;
            end
        end
        @(negedge clk);
        query_pos   = pos;
        query_valid = 1'b1;
        #1 rdy = query_ready;
        @(posedge clk); #1;
        query_valid = 1'b0;
        n_tests++;
        if (rdy !== e_rdy || resp_valid !== e_rdy || resp_hit !== e_hit
            || resp_repeat !== e_rep || shot_map !== model_map(1'b1)) begin
            n_fail++;
            $display("FAIL %s pos=%h: rdy=%b rv=%b hit=%b rep=%b, need %b %b %b %b (shot map %s)",
                     name, pos, rdy, resp_valid, resp_hit, resp_repeat, e_rdy, e_rdy, e_hit,
                     e_rep, shot_map === model_map(1'b1) ? "ok" : "differs");
        end
        @(posedge clk); #1;
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: resp_valid=%b, need 0", name, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({place_ack, place_err, ship_count, board_full, query_ready, resp_valid, resp_hit,
             resp_repeat, all_sunk} !== 13'b0 || occ_map !== '0 || shot_map !== '0) begin
            n_fail++;
            $display("FAIL reset: ack=%b err=%b cnt=%0d full=%b rdy=%b rv=%b sunk=%b, need all 0",
                     place_ack, place_err, ship_count, board_full, query_ready, resp_valid,
                     all_sunk);
        end
    endtask

    task automatic test_directed_place();
        test_place_one(8'h23, "place_23");
        n_tests++;
        if (occ_map[23] !== 1'b1 || ship_count !== 4'd1) begin
            n_fail++;
            $display("FAIL occ_bit23: bit=%b count=%0d, need 1 1", occ_map[23], ship_count);
        end
        test_place_one(8'h34, "place_diag_34");
        test_place_one(8'h25, "place_25");
        test_place_one(8'hA0, "place_row_oob");
        test_place_one(8'h0F, "place_col_oob");
    endtask

    task automatic test_reset_mid_check();
        int pul;
        pulse_reset(1'b0);
        test_place_one(8'h55, "pre_abort");
        @(negedge clk);
        cell_pos  = 8'h00;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pul = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (place_ack || place_err) pul++;
        end
        n_tests++;
        if (pul !== 0 || ship_count !== 4'd0 || occ_map !== '0) begin
            n_fail++;
            $display("FAIL abort_check: pulses=%0d count=%0d occ=%h, need 0 0 0", pul,
                     ship_count, occ_map);
        end
        test_place_one(8'h00, "place_after_abort");
    endtask

    task automatic test_random_fill();
        logic [7:0] pos;
        pulse_reset(1'b1);
        for (int i = 0; i < 30 && m_count < MS; i++) begin
            if ($urandom_range(0, 4) == 0) pos = 8'($urandom_range(0, 255));
            else pos = {4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1))};
            test_place_one(pos, "rand_place");
        end
        for (int r = 0; r < N && m_count < MS; r++)
            for (int c = 0; c < N && m_count < MS; c++)
                if (model_legal(r, c)) test_place_one({4'(r), 4'(c)}, "fill_place");
        n_tests++;
        if (board_full !== 1'b1 || query_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL armed: full=%b ready=%b, need 1 1", board_full, query_ready);
        end
        test_place_one({4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1))},
                       "place_when_full");
    endtask

    task automatic test_shoot();
        logic [7:0] pos;
        int sel, e;
        test_shot_one(ship_q[0], "shot_ship");
        test_shot_one(ship_q[0], "shot_repeat");
        e = -1;
        for (int i = 0; i < NC && e < 0; i++)
            if (!m_occ[i/N][i%N] && !m_shot[i/N][i%N]) e = i;
        test_shot_one({4'(e / N), 4'(e % N)}, "shot_empty");
        for (int i = 0; i < 200 && m_hits < MS; i++) begin
            sel = $urandom_range(0, 5);
            if (sel < 2) pos = ship_q[$urandom_range(0, ship_q.size() - 1)];
            else if (sel < 5) pos = {4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1))};
            else pos = {4'($urandom_range(N, 15)), 4'($urandom_range(0, 15))};
            test_shot_one(pos, "rand_shot");
        end
        for (int i = 0; i < ship_q.size() && m_hits < MS; i++)
            test_shot_one(ship_q[i], "sweep_shot");
        e = 0;
        while (all_sunk !== 1'b1 && e < 5) begin
            @(posedge clk); #1;
            e++;
        end
        n_tests++;
        if (all_sunk !== 1'b1 || query_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL all_sunk: sunk=%b ready=%b, need 1 0", all_sunk, query_ready);
        end
    endtask

    task automatic test_dropped_query();
        int rv;
        @(negedge clk);
        query_pos   = ship_q[0];
        query_valid = 1'b1;
        rv = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) rv++;
        end
        query_valid = 1'b0;
        n_tests++;
        if (rv !== 0 || shot_map !== model_map(1'b1) || all_sunk !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped_query: resp=%0d sunk=%b, need 0 1", rv, all_sunk);
        end
    endtask

    task automatic test_clear();
        pulse_reset(1'b1);
        #1;
        n_tests++;
        if (ship_count !== 4'd0 || board_full !== 1'b0 || all_sunk !== 1'b0
            || query_ready !== 1'b0 || occ_map !== '0 || shot_map !== '0) begin
            n_fail++;
            $display("FAIL clear: cnt=%0d full=%b sunk=%b rdy=%b, need 0 0 0 0", ship_count,
                     board_full, all_sunk, query_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed_place();
        test_reset_mid_check();
        test_random_fill();
        test_shoot();
        test_dropped_query();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ship_board.md
SHIP_BOARD -- requirements
Module: ship_board

Interface
REQ-001 SHALL have parameter BOARD_N, default 10, board edge length in cells.
REQ-002 SHALL have parameter MAX_SHIPS, default 10, number of single-cell ships per board.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous board wipe, same effect as rst, lower priority than rst.
REQ-006 SHALL have port place_req  input  1  placement request level (driven by game controller pick_ship); acted on at rising edge only.
REQ-007 SHALL have port cell_pos  input  8  target cell; [7:4] row, [3:0] column.
REQ-008 SHALL have port place_ack  output  1  one-cycle pulse, ship placed.
REQ-009 SHALL have port place_err  output  1  one-cycle pulse, placement rejected.
REQ-010 SHALL have port ship_count  output  4  ships placed so far (feeds game controller).
REQ-011 SHALL have port board_full  output  1  high when ship_count == MAX_SHIPS.
REQ-012 SHALL have port query_valid  input  1  shot request valid.
REQ-013 SHALL have port query_pos  input  8  shot cell; [7:4] row, [3:0] column.
REQ-014 SHALL have port query_ready  output  1  shot can be accepted this cycle.
REQ-015 SHALL have port resp_valid  output  1  one-cycle pulse, shot result valid.
REQ-016 SHALL have port resp_hit  output  1  shot hit an intact ship; valid with resp_valid.
REQ-017 SHALL have port resp_repeat  output  1  shot cell already fired at; valid with resp_valid.
REQ-018 SHALL have port all_sunk  output  1  high when every placed ship is hit.
REQ-019 SHALL have port occ_map  output  BOARD_N*BOARD_N  ship occupancy, bit index row*BOARD_N+col, for drawing.
REQ-020 SHALL have port shot_map  output  BOARD_N*BOARD_N  cells fired at, same indexing.

Function
REQ-021 SHALL implement states READY, CHECK, COMMIT, ARMED.
REQ-022 SHALL register place_req and detect rising edge as place_req & ~place_req_q.
REQ-023 In READY, on rising edge at cycle T with row>=BOARD_N or col>=BOARD_N (incl. wrapped values 10..15), SHALL pulse place_err at T+1 and stay READY.
REQ-024 In READY, on valid rising edge at T, SHALL latch cell_pos and enter CHECK at T+1.
REQ-025 CHECK SHALL scan 9 offsets (drow,dcol in -1..+1) with 4-bit counter, one per cycle, T+1..T+9; off-board neighbours count as free.
REQ-026 SHALL set a conflict flag if target or any 8-neighbour cell is occupied (no touching ships, diagonal included).
REQ-027 COMMIT at T+10 SHALL: on conflict pulse place_err; else set occ bit, increment ship_count, pulse place_ack.
REQ-028 After COMMIT SHALL go to ARMED if ship_count reaches MAX_SHIPS, else READY.
REQ-029 Rising edges of place_req during CHECK, COMMIT or ARMED SHALL be ignored, no pulse.
REQ-030 ship_count SHALL saturate at MAX_SHIPS; never wraps.
REQ-031 query_ready SHALL equal (state == ARMED) & ~all_sunk.
REQ-032 On query_valid & query_ready at T, SHALL pulse resp_valid at T+1.
REQ-033 Out-of-range query_pos SHALL give resp_hit=0, resp_repeat=0, no map change.
REQ-034 Query to cell with shot bit already set SHALL give resp_repeat=1, resp_hit=0, no map change.
REQ-035 Otherwise SHALL set shot bit; resp_hit=occ bit; on hit increment internal hit counter.
REQ-036 all_sunk SHALL assert the cycle after hit counter reaches MAX_SHIPS and hold until rst/clear.
REQ-037 query_valid without query_ready SHALL be dropped, no resp_valid.

Reset
REQ-038 On rst or clear: state READY, occ_map=0, shot_map=0, ship_count=0, hit counter=0, place_req_q=0, all pulse outputs 0, all_sunk=0, board_full=0.
REQ-039 rst/clear mid-CHECK SHALL abort the placement with no ack/err pulse.

Verification
REQ-040 Place at 0x23 -> place_ack 10 cycles after edge, ship_count=1, occ_map bit 23 set.
REQ-041 After 0x23, place at 0x34 (diagonal) -> place_err at T+10, ship_count stays 1; place at 0x25 -> ack.
REQ-042 Place at 0xA0 and 0x0F -> place_err at T+1 each, no map change.
REQ-043 Place 10 legal non-touching ships -> board_full=1, state ARMED, 11th edge ignored, query_ready=1.
REQ-044 ARMED: shoot ship cell -> resp_hit=1; same cell again -> resp_repeat=1; empty cell -> resp_hit=0; hit all 10 -> all_sunk=1, query_ready=0.
REQ-045 Assert rst during CHECK -> no pulse, ship_count=0, next placement at 0x00 accepted.
